// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive deserializer: synchronizes async SCLK/CS_N/MOSI into clk,
// assembles WIDTH-bit words MSB first and reports word, bit index and framing errors.
module spi_slave_rx #(
  parameter int WIDTH       = 16,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t                 state;
  logic [WIDTH-1:0]       shift;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [SYNC_STAGES:0]   warm;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic ready;
  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;
  logic [WIDTH-1:0] shift_next;

  // Synchronizers idle at the bus-idle levels so reset itself never looks like an edge.
  // NOTE: every flop here is reset, including the synchronizer chains; none of this is a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      warm      <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // A cs_n held low through reset release would ripple out as a false falling edge;
  // frames may only start once the chain has flushed.
  assign ready = warm[SYNC_STAGES];

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign cs_fall    = ~cs_s & cs_d;
  assign cs_rise    = cs_s & ~cs_d;
  assign shift_next = {shift[WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (cs_fall && ready) begin
            state <= SHIFT;
            busy  <= 1'b1;
            shift <= '0;
          end
        end
        SHIFT: begin
          // cs_rise takes priority, so a coincident sclk edge is dropped with the partial word.
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_err <= (bit_cnt != '0);
          end else if (sclk_rise && !cs_s) begin
            shift <= shift_next;
            if (bit_cnt == LAST_BIT) begin
              data_out   <= shift_next;
              data_valid <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
